make_go_fast_hls_deadlock_report_ctrl: RTL and testbench

Central controller on the consuming end of the per-process deadlock detect units in the make_go_fast HLS dataflow region. It collects every unit's deadlock flag, confirms a persistent deadlock, and elects a single origin process. It then walks the dependency token around the cycle and presents one latched report: origin, processes and channels on the cycle, and cycle length. That report goes to a host-side reader over a valid/ready handshake.

---
 rtl/make_go_fast_dl_pkg.sv | 24 ++
 rtl/make_go_fast_hls_deadlock_report_ctrl_if.sv | 30 +++
 rtl/make_go_fast_dl_prio_enc.sv | 23 ++
 rtl/make_go_fast_hls_deadlock_report_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_make_go_fast_hls_deadlock_report_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/make_go_fast_dl_pkg.sv
// Shared definitions for the make_go_fast deadlock report controller:
// controller state encoding, default region sizes, report field widths.
package make_go_fast_dl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONFIRM = 3'd1,
        S_ORIGIN  = 3'd2,
        S_TRACE   = 3'd3,
        S_REPORT  = 3'd4,
        S_HOLD    = 3'd5
    } dl_state_e;

    // Width of a process index; a single-process region still needs one bit.
    function automatic int pid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DL_PROC_NUM = 4;
    localparam int DL_CHAN_NUM = 8;
    localparam int PID_W       = pid_width(DL_PROC_NUM);
    localparam int LEN_W       = PID_W + 1;

endpackage

// File: rtl/make_go_fast_hls_deadlock_report_ctrl_if.sv
// Report handshake bundle between the deadlock controller (master) and the
// host-side reader (slave).
interface make_go_fast_hls_deadlock_report_ctrl_if
    import make_go_fast_dl_pkg::*;
#(
    parameter int PROC_NUM = DL_PROC_NUM,
    parameter int CHAN_NUM = DL_CHAN_NUM
);
    localparam int PW = pid_width(PROC_NUM);
    localparam int LW = PW + 1;

    logic                rpt_valid;
    logic                rpt_ready;
    logic [PW-1:0]       rpt_origin;
    logic [PROC_NUM-1:0] rpt_proc_mask;
    logic [CHAN_NUM-1:0] rpt_chan_mask;
    logic [LW-1:0]       rpt_len;
    logic                rpt_partial;

    modport master (
        output rpt_valid, rpt_origin, rpt_proc_mask, rpt_chan_mask, rpt_len, rpt_partial,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid, rpt_origin, rpt_proc_mask, rpt_chan_mask, rpt_len, rpt_partial,
        output rpt_ready
    );

endinterface

// File: rtl/make_go_fast_dl_prio_enc.sv
// Lowest-index priority encoder: index of the lowest set bit plus a valid flag.
module make_go_fast_dl_prio_enc
    import make_go_fast_dl_pkg::*;
#(
    parameter int N = DL_PROC_NUM
) (
    input  logic [N-1:0]              in_i,
    output logic [pid_width(N)-1:0]   idx_o,
    output logic                      valid_o
);
    localparam int W = pid_width(N);

    // Scan from the top down so the lowest set bit is written last and wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_o   = in_i[i] ? W'(i) : idx_o;
            valid_o = valid_o | in_i[i];
        end
    end

endmodule

// File: rtl/make_go_fast_hls_deadlock_report_ctrl.sv
// Deadlock report controller: confirms a persistent deadlock flag, elects the
// lowest flagged process as origin, follows the dependency token around the
// cycle and latches one report for the host reader.
// Optional trace watchdog: define MAKE_GO_FAST_DL_TIMEOUT_EN.
module make_go_fast_hls_deadlock_report_ctrl
    import make_go_fast_dl_pkg::*;
#(
    parameter int PROC_NUM    = DL_PROC_NUM,
    parameter int CHAN_NUM    = DL_CHAN_NUM,
    parameter int CONFIRM_CYC = 4,
    parameter int TRACE_MAX   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PROC_NUM-1:0] dl_detect_vec_i,
    input  logic [PROC_NUM-1:0] proc_token_vec_i,
    input  logic [CHAN_NUM-1:0] chan_token_vec_i,
    output logic [PROC_NUM-1:0] origin_vec_o,
    output logic                token_clear_o,
    output logic                deadlock_flag_o,
    input  logic                rearm_i,
    make_go_fast_hls_deadlock_report_ctrl_if.master rpt_if
);
    localparam int PW = pid_width(PROC_NUM);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(CONFIRM_CYC + 1);

    dl_state_e           state_q;
    logic [CW-1:0]       confirm_cnt_q;
    logic [PW-1:0]       origin_q;
    logic [PROC_NUM-1:0] origin_vec_q;
    logic [PROC_NUM-1:0] proc_mask_q;
    logic [CHAN_NUM-1:0] chan_mask_q;
    logic [LW-1:0]       len_q;
    logic                valid_q;
    logic                flag_q;

    logic [PW-1:0]       enc_idx_s;
    logic                enc_valid_s;
    logic [PROC_NUM-1:0] proc_mask_d;
    logic [CHAN_NUM-1:0] chan_mask_d;
    logic [LW-1:0]       len_d;
    logic                ret_s;
    logic                timeout_s;

    make_go_fast_dl_prio_enc #(.N(PROC_NUM)) u_prio_enc (
        .in_i    (dl_detect_vec_i),
        .idx_o   (enc_idx_s),
        .valid_o (enc_valid_s)
    );

    assign proc_mask_d = proc_mask_q | proc_token_vec_i;
    assign chan_mask_d = chan_mask_q | chan_token_vec_i;
    assign ret_s       = (state_q == S_TRACE) && proc_token_vec_i[origin_q];

    // Popcount of the mask that will be latched this cycle.
    always_comb begin
        len_d = '0;
        for (int i = 0; i < PROC_NUM; i++) begin
            len_d = len_d + LW'(proc_mask_d[i]);
        end
    end

`ifdef MAKE_GO_FAST_DL_TIMEOUT_EN
    localparam int TW = $clog2(TRACE_MAX + 1);
    logic [TW-1:0] trace_cnt_q;
    logic          partial_q;

    assign timeout_s = (state_q == S_TRACE) && (trace_cnt_q == TW'(TRACE_MAX - 1));

    // Trace watchdog: counts TRACE cycles; a token return in the expiry cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_cnt_q <= '0;
            partial_q   <= 1'b0;
        end else if (state_q == S_ORIGIN) begin
            trace_cnt_q <= '0;
            partial_q   <= 1'b0;
        end else if (state_q == S_TRACE) begin
            trace_cnt_q <= trace_cnt_q + TW'(1);
            partial_q   <= timeout_s & ~ret_s;
        end else begin
            trace_cnt_q <= trace_cnt_q;
            partial_q   <= partial_q;
        end
    end

    assign rpt_if.rpt_partial = partial_q;
`else
    localparam int unused_trace_max = TRACE_MAX;
    assign timeout_s          = 1'b0;
    assign rpt_if.rpt_partial = 1'b0;
`endif

    // The origin strobe is one cycle wide, so token_clear must follow the
    // return in the same cycle rather than a cycle later.
    assign token_clear_o = ret_s | timeout_s;

    // Controller FSM and all latched report state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            confirm_cnt_q <= '0;
            origin_q      <= '0;
            origin_vec_q  <= '0;
            proc_mask_q   <= '0;
            chan_mask_q   <= '0;
            len_q         <= '0;
            valid_q       <= 1'b0;
            flag_q        <= 1'b0;
        end else begin
            origin_vec_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (enc_valid_s) begin
                        confirm_cnt_q <= CW'(1);
                        if (CONFIRM_CYC <= 1) begin
                            origin_q <= enc_idx_s;
                            state_q  <= S_ORIGIN;
                        end else begin
                            state_q  <= S_CONFIRM;
                        end
                    end else begin
                        confirm_cnt_q <= '0;
                    end
                end
                S_CONFIRM: begin
                    if (!enc_valid_s) begin
                        confirm_cnt_q <= '0;
                        state_q       <= S_IDLE;
                    end else if (confirm_cnt_q == CW'(CONFIRM_CYC - 1)) begin
                        confirm_cnt_q <= '0;
                        origin_q      <= enc_idx_s;
                        state_q       <= S_ORIGIN;
                    end else begin
                        confirm_cnt_q <= confirm_cnt_q + CW'(1);
                    end
                end
                S_ORIGIN: begin
                    origin_vec_q <= {{(PROC_NUM-1){1'b0}}, 1'b1} << origin_q;
                    proc_mask_q  <= '0;
                    chan_mask_q  <= '0;
                    len_q        <= '0;
                    state_q      <= S_TRACE;
                end
                S_TRACE: begin
                    proc_mask_q <= proc_mask_d;
                    chan_mask_q <= chan_mask_d;
                    len_q       <= len_d;
                    if (ret_s || timeout_s) begin
                        valid_q <= 1'b1;
                        flag_q  <= 1'b1;
                        state_q <= S_REPORT;
                    end else begin
                        state_q <= S_TRACE;
                    end
                end
                S_REPORT: begin
                    if (rpt_if.rpt_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_HOLD;
                    end else begin
                        state_q <= S_REPORT;
                    end
                end
                S_HOLD: begin
                    if (rearm_i) begin
                        flag_q      <= 1'b0;
                        proc_mask_q <= '0;
                        chan_mask_q <= '0;
                        len_q       <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q     <= S_HOLD;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign origin_vec_o         = origin_vec_q;
    assign deadlock_flag_o      = flag_q;
    assign rpt_if.rpt_valid     = valid_q;
    assign rpt_if.rpt_origin    = origin_q;
    assign rpt_if.rpt_proc_mask = proc_mask_q;
    assign rpt_if.rpt_chan_mask = chan_mask_q;
    assign rpt_if.rpt_len       = len_q;

endmodule

// File: tb/tb_make_go_fast_hls_deadlock_report_ctrl.sv
// Directed bench for the deadlock report controller (PROC_NUM=4, CHAN_NUM=8,
// CONFIRM_CYC=4, TRACE_MAX=16). Cycle numbers are relative to the first cycle
// the detect flag is driven.
module tb_make_go_fast_hls_deadlock_report_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dl;
    logic [3:0] ptok;
    logic [7:0] ctok;
    logic [3:0] ovec;
    logic       tclr;
    logic       dflag;
    logic       rearm;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef MAKE_GO_FAST_DL_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    make_go_fast_hls_deadlock_report_ctrl_if #(.PROC_NUM(4), .CHAN_NUM(8)) rif ();

    make_go_fast_hls_deadlock_report_ctrl #(
        .PROC_NUM(4), .CHAN_NUM(8), .CONFIRM_CYC(4), .TRACE_MAX(16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .dl_detect_vec_i  (dl),
        .proc_token_vec_i (ptok),
        .chan_token_vec_i (ctok),
        .origin_vec_o     (ovec),
        .token_clear_o    (tclr),
        .deadlock_flag_o  (dflag),
        .rearm_i          (rearm),
        .rpt_if           (rif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_rpt(input logic [1:0] org, input logic [3:0] pm, input logic [7:0] cm,
                           input logic [2:0] len, input logic part);
        chk("rpt_origin", 32'(rif.rpt_origin), 32'(org));
        chk("rpt_proc_mask", 32'(rif.rpt_proc_mask), 32'(pm));
        chk("rpt_chan_mask", 32'(rif.rpt_chan_mask), 32'(cm));
        chk("rpt_len", 32'(rif.rpt_len), 32'(len));
        chk("rpt_partial", 32'(rif.rpt_partial), 32'(part));
    endtask

    task automatic drive(input logic [3:0] d, input logic [3:0] p, input logic [7:0] c,
                         input logic rd, input logic ra);
        dl            = d;
        ptok          = p;
        ctok          = c;
        rif.rpt_ready = rd;
        rearm         = ra;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // reset state
        chk("rst_origin_vec", 32'(ovec), 32'h0);
        chk("rst_token_clear", 32'(tclr), 32'h0);
        chk("rst_valid", 32'(rif.rpt_valid), 32'h0);
        chk("rst_flag", 32'(dflag), 32'h0);
        chk_rpt(2'd0, 4'h0, 8'h00, 3'd0, 1'b0);

        // glitch: three cycles of flag must not start a trace
        for (int c = 0; c < 8; c++) begin
            drive((c < 3) ? 4'b0010 : 4'b0000, 4'h0, 8'h00, 1'b0, 1'b0);
            #1;
            chk("glitch_origin_vec", 32'(ovec), 32'h0);
            chk("glitch_flag", 32'(dflag), 32'h0);
            chk("glitch_valid", 32'(rif.rpt_valid), 32'h0);
            cyc();
        end

        // full cycle P1->ch3->P2->ch5->P1 with 10 cycles of back-pressure
        for (int c = 0; c < 20; c++) begin
            drive(4'b0110,
                  (c == 6) ? 4'b0100 : (c == 7) ? 4'b0010 : 4'b0000,
                  (c == 6) ? 8'h08   : (c == 7) ? 8'h20   : 8'h00,
                  (c >= 18), 1'b0);
            #1;
            chk("full_origin_vec", 32'(ovec), (c == 5) ? 32'h2 : 32'h0);
            chk("full_token_clear", 32'(tclr), (c == 7) ? 32'h1 : 32'h0);
            chk("full_valid", 32'(rif.rpt_valid), (c >= 8 && c <= 18) ? 32'h1 : 32'h0);
            chk("full_flag", 32'(dflag), (c >= 8) ? 32'h1 : 32'h0);
            if (c >= 8) chk_rpt(2'd1, 4'b0110, 8'h28, 3'd2, 1'b0);
            cyc();
        end

        // rearm from HOLD
        drive(4'h0, 4'h0, 8'h00, 1'b0, 1'b1);
        cyc();
        drive(4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("rearm_flag", 32'(dflag), 32'h0);
        chk("rearm_valid", 32'(rif.rpt_valid), 32'h0);
        chk("rearm_proc_mask", 32'(rif.rpt_proc_mask), 32'h0);
        chk("rearm_chan_mask", 32'(rif.rpt_chan_mask), 32'h0);
        cyc();

        // P3 origin, rearm during TRACE ignored, ready held high in advance
        for (int c = 0; c < 11; c++) begin
            drive((c < 4) ? 4'b1000 : 4'b0000,
                  (c == 7) ? 4'b0001 : (c == 8) ? 4'b1000 : 4'b0000,
                  (c == 7) ? 8'h80   : (c == 8) ? 8'h01   : 8'h00,
                  1'b1, (c == 6));
            #1;
            chk("p3_origin_vec", 32'(ovec), (c == 5) ? 32'h8 : 32'h0);
            chk("p3_token_clear", 32'(tclr), (c == 8) ? 32'h1 : 32'h0);
            chk("p3_valid", 32'(rif.rpt_valid), (c == 9) ? 32'h1 : 32'h0);
            chk("p3_flag", 32'(dflag), (c >= 9) ? 32'h1 : 32'h0);
            if (c == 9) chk_rpt(2'd3, 4'b1001, 8'h81, 3'd2, 1'b0);
            cyc();
        end
        drive(4'h0, 4'h0, 8'h00, 1'b0, 1'b1);
        cyc();
        drive(4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("p3_rearm_flag", 32'(dflag), 32'h0);
        cyc();

        // asynchronous reset in the middle of a trace
        for (int c = 0; c < 8; c++) begin
            drive((c < 4) ? 4'b0100 : 4'b0000,
                  (c == 6) ? 4'b0001 : (c == 7) ? 4'b0100 : 4'b0000,
                  (c == 6) ? 8'h02   : (c == 7) ? 8'h10   : 8'h00,
                  1'b0, 1'b0);
            #1;
            chk("rt_origin_vec", 32'(ovec), (c == 5) ? 32'h4 : 32'h0);
            if (c < 7) cyc();
        end
        chk("rt_token_clear_pre", 32'(tclr), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rt_token_clear", 32'(tclr), 32'h0);
        chk("rt_origin_vec_rst", 32'(ovec), 32'h0);
        chk("rt_valid", 32'(rif.rpt_valid), 32'h0);
        chk("rt_flag", 32'(dflag), 32'h0);
        chk_rpt(2'd0, 4'h0, 8'h00, 3'd0, 1'b0);
        drive(4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        cyc();

        // restart after reset: P1 origin, immediate return
        for (int c = 0; c < 10; c++) begin
            drive((c < 4) ? 4'b0010 : 4'b0000,
                  (c == 6) ? 4'b0010 : 4'b0000, 8'h00, 1'b1, (c == 8));
            #1;
            chk("rs_origin_vec", 32'(ovec), (c == 5) ? 32'h2 : 32'h0);
            chk("rs_token_clear", 32'(tclr), (c == 6) ? 32'h1 : 32'h0);
            chk("rs_valid", 32'(rif.rpt_valid), (c == 7) ? 32'h1 : 32'h0);
            chk("rs_flag", 32'(dflag), (c == 7 || c == 8) ? 32'h1 : 32'h0);
            if (c == 7) chk_rpt(2'd1, 4'b0010, 8'h00, 3'd1, 1'b0);
            cyc();
        end

        // watchdog: token leaves P0 and never returns
        for (int c = 0; c < 23; c++) begin
            drive((c < 4) ? 4'b0001 : 4'b0000,
                  (c == 6) ? 4'b0100 : 4'b0000,
                  (c == 6) ? 8'h04   : 8'h00, 1'b0, 1'b0);
            #1;
            chk("wd_origin_vec", 32'(ovec), (c == 5) ? 32'h1 : 32'h0);
            chk("wd_token_clear", 32'(tclr), (WD_EN && c == 20) ? 32'h1 : 32'h0);
            chk("wd_valid", 32'(rif.rpt_valid), (WD_EN && c >= 21) ? 32'h1 : 32'h0);
            chk("wd_partial", 32'(rif.rpt_partial), (WD_EN && c >= 21) ? 32'h1 : 32'h0);
            if (c >= 7) begin
                chk("wd_proc_mask", 32'(rif.rpt_proc_mask), 32'h4);
                chk("wd_chan_mask", 32'(rif.rpt_chan_mask), 32'h04);
                chk("wd_len", 32'(rif.rpt_len), 32'h1);
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
